// File: rtl/ex_hazard_ctrl_pkg.sv
// rtl/ex_hazard_ctrl_pkg.sv - shared opcode, forward-select and FSM encodings for the EX hazard controller
package ex_hazard_ctrl_pkg;

  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int MC_CNT_W = 4;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } hz_state_e;

  // x0 is hard-wired to zero, so a write to it never produces a forward.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mem_rd, input logic mem_we,
                                         input logic [4:0] wb_rd,  input logic wb_we);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_NONE;
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_fwd.sv
// rtl/ex_hazard_ctrl_fwd.sv - hazard_fwd_unit: combinational two-operand forward compare, MEM over WB
module hazard_fwd_unit
  import ex_hazard_ctrl_pkg::*;
(
  input  logic [4:0] idex_rs1,
  input  logic [4:0] idex_rs2,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(idex_rs1, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
  assign fwd_b = fwd_sel(idex_rs2, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX forwarding, load-use stall, redirect flush and multi-cycle sequencing
// Optional saturating stall/flush performance counters under HAZ_PERF_CNT_EN.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic [4:0]       idex_rs1,
  input  logic [4:0]       idex_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_is_load,
  input  logic             idex_mc_op,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [4:0]       memwb_rd,
  input  logic             memwb_regwrite,
  input  logic             ex_redirect,
  output logic [1:0]       forward_select_A,
  output logic [1:0]       forward_select_B,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             hold_ex,
  output logic             flush_id,
  output logic             mc_done,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The entry cycle is spent in RUN, so the counter covers the remaining cycles minus the final one.
  localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'(MC_LATENCY - 2);

  hz_state_e            state_q, state_d;
  logic [MC_CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]           fwd_a, fwd_b;
  logic                 load_use;

  hazard_fwd_unit u_fwd (
    .idex_rs1       (idex_rs1),
    .idex_rs2       (idex_rs2),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  assign forward_select_A = rst ? FWD_NONE : fwd_a;
  assign forward_select_B = rst ? FWD_NONE : fwd_b;

  assign load_use = idex_is_load && (idex_rd != 5'd0) &&
                    ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                     (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    hold_ex   = 1'b0;
    flush_id  = 1'b0;
    mc_done   = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          // Priority: multi-cycle entry, then redirect, then load-use.
          if (idex_mc_op) begin
            state_d  = ST_MC_BUSY;
            cnt_d    = MC_LOAD;
            stall_if = 1'b1;
            stall_id = 1'b1;
            hold_ex  = 1'b1;
          end else if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
          end else if (load_use) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        ST_MC_BUSY: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          busy     = 1'b1;
          if (cnt_q == '0) begin
            mc_done = 1'b1;
            state_d = ST_RUN;
          end else begin
            hold_ex = 1'b1;
            cnt_d   = cnt_q - 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_if && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_id && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core. It owns the execution stage's operand-forward selects and the stall/flush/bubble controls.
- Forward selects are combinational compares across EX/MEM/WB destinations. Load-use stalls are inserted here.
- Multi-cycle EX operations are sequenced by a small FSM with a latency counter.
- Sits beside the ID/EX and EX/MEM pipeline registers; drives IF/ID/EX enables and forward_select_A/B.

Parameters:
- MC_LATENCY, 4, total EX cycles for a multi-cycle op (legal range 2..16).
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID.
- ifid_uses_rs1, ifid_uses_rs2  in  1 each  ID instruction reads that source.
- idex_rs1, idex_rs2  in  5 each  source registers of the instruction in EX.
- idex_rd  in  5  destination of the EX instruction.
- idex_is_load  in  1  EX instruction is I_TYPE_LOAD.
- idex_mc_op  in  1  EX instruction is multi-cycle (MUL/DIV class).
- exmem_rd  in  5  destination in MEM.
- exmem_regwrite  in  1  MEM instruction writes rd.
- memwb_rd  in  5  destination in WB.
- memwb_regwrite  in  1  WB instruction writes rd.
- ex_redirect  in  1  taken branch/jump resolved in EX.
- forward_select_A, forward_select_B  out  2 each  00 none, 01 WB, 10 MEM.
- stall_if, stall_id  out  1 each  hold PC and IF/ID.
- bubble_ex  out  1  load NOP into ID/EX.
- hold_ex  out  1  hold ID/EX contents and insert a NOP into EX/MEM.
- flush_id  out  1  clear IF/ID.
- mc_done  out  1  final cycle of a multi-cycle op; EX result is valid.
- busy  out  1  FSM is not in RUN.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
Reset:
- Async on rst high: FSM=RUN, counter=0, performance counters=0.
- All 1-bit outputs are 0 and forward selects are 00 while rst is high.

Forwarding (combinational, every cycle, per operand X in {rs1, rs2}):
- 10 if exmem_regwrite and exmem_rd!=0 and exmem_rd==idex_X.
- Otherwise 01 if memwb_regwrite and memwb_rd!=0 and memwb_rd==idex_X.
- Otherwise 00. MEM has priority over WB.

FSM states:
- RUN
  - Load-use: idex_is_load, idex_rd!=0, and (ifid_uses_rs1 and ifid_rs1==idex_rd) or (ifid_uses_rs2 and ifid_rs2==idex_rd).
    - Assert stall_if, stall_id, bubble_ex the same cycle, combinationally. Stay in RUN; the hazard clears next cycle.
  - idex_mc_op=1 (and rst low): go to MC_BUSY, counter loads MC_LATENCY-2.
    - In this entry cycle, assert stall_if, stall_id, hold_ex combinationally.
    - Forward selects continue to be computed normally.
  - ex_redirect=1: assert flush_id and bubble_ex.
    - Redirect overrides load-use: no stall_if/stall_id, so the PC may load the target.
  - If idex_mc_op and ex_redirect are both set, mc wins. The redirect is re-sampled when the op completes; EX holds, so ex_redirect is stable.
- MC_BUSY
  - Assert stall_if, stall_id, hold_ex, busy.
  - Counter decrements each cycle. When counter==0, assert mc_done, deassert hold_ex, and return to RUN next edge.
  - Total EX occupancy = MC_LATENCY cycles, with mc_done on the last one.
  - Load-use and redirect detection are suppressed in MC_BUSY.
- Reset mid-MC_BUSY: immediate return to RUN; no mc_done pulse.

Rules:
- idex_rd==0 never causes a stall or a forward.
- Counter width is 4 bits.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - stall_cnt increments on every cycle in which stall_if=1.
  - flush_cnt increments on every cycle in which flush_id=1.
  - Both counters saturate at all-ones and clear on rst.
- HAZ_PERF_CNT_EN undefined: no counter flops; stall_cnt and flush_cnt are tied to 0.

Decomposition:
- Shared defines file:
  - I_TYPE_LOAD opcode.
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - FSM state encodings ST_RUN, ST_MC_BUSY.
- Sub-module hazard_fwd_unit: the purely combinational two-operand forward compare, instantiated once inside ex_hazard_ctrl.

Test Plan:
- add x5,..; add x6,x5,x1 back-to-back (exmem_rd=5, regwrite=1, idex_rs1=5) -> forward_select_A=10, B=00, no stall.
- exmem_rd=7 and memwb_rd=7, both regwrite, idex_rs2=7 -> forward_select_B=10 (MEM priority). memwb_rd=0 with idex_rs1=0 -> A=00.
- lw x3 in EX (idex_is_load=1, idex_rd=3), ifid_rs2=3, uses_rs2=1 -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle. Same case with rd=0 -> no stall.
- idex_mc_op pulse with MC_LATENCY=4 -> stall_if/stall_id held 4 cycles, hold_ex high for cycles 1-3, mc_done high only in cycle 4, busy high cycles 2-4.
- ex_redirect=1 concurrent with a load-use match -> flush_id=1, bubble_ex=1, stall_if=0.
- rst asserted in MC_BUSY cycle 2 -> all outputs 0 asynchronously, FSM in RUN, no mc_done. With HAZ_PERF_CNT_EN defined: 3 stalls then reset -> stall_cnt 3 then 0.
